// File: rtl/addsub_op_sequencer_pkg.sv
// addsub_op_sequencer_pkg
//   Shared definitions for the add/sub operation sequencer. These are the
//   command opcodes, the bit positions of the status flags, the FSM state
//   codes and the datapath width.
package addsub_op_sequencer_pkg;

  localparam int DATA_W = 4;

  typedef logic [1:0] op_t;

  localparam op_t OP_LOAD = 2'b00;
  localparam op_t OP_ADD  = 2'b01;
  localparam op_t OP_SUB  = 2'b10;
  localparam op_t OP_CMP  = 2'b11;

  // Flag vector layout is {C,V,N,Z}.
  localparam int FLG_C = 3;
  localparam int FLG_V = 2;
  localparam int FLG_N = 1;
  localparam int FLG_Z = 0;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_EXEC = 2'd1;
  localparam logic [1:0] ST_RESP = 2'd2;

endpackage

// File: rtl/addsub_op_sequencer_flag_gen.sv
// addsub_flag_gen
//   Combinational result/flag generation for one sequencer operation. It
//   takes the operands that were presented to the external adder-subtractor
//   and the adder's answer, and produces the final result and {C,V,N,Z}.
//
//   Configuration macro: ADDSUB_SAT_EN. When it is defined, a signed overflow
//   on ADD or SUB clamps the result to the signed extreme on the side of
//   operand A. CMP is never clamped.
//
//   Ports:
//     i_a, i_b   operands driven to adder A/B (i_b is the command data)
//     i_m        adder mode (1 = subtract)
//     i_sum      adder Sum
//     i_carry    adder Carry
//     i_op       operation code
//     o_result   final (post-clamp) result
//     o_flags    {C,V,N,Z}
module addsub_flag_gen
  import addsub_op_sequencer_pkg::*;
(
  input  logic [DATA_W-1:0] i_a,
  input  logic [DATA_W-1:0] i_b,
  input  logic              i_m,
  input  logic [DATA_W-1:0] i_sum,
  input  logic              i_carry,
  input  logic [1:0]        i_op,
  output logic [DATA_W-1:0] o_result,
  output logic [3:0]        o_flags
);

  logic [DATA_W-1:0] w_bx;
  logic              w_v_raw;
  logic [DATA_W-1:0] w_res;
  logic              w_c;
  logic              w_v;

  // The B operand as the adder actually sees it, after the subtract inversion.
  assign w_bx    = i_b ^ {DATA_W{i_m}};
  assign w_v_raw = (i_a[DATA_W-1] == w_bx[DATA_W-1]) &&
                   (i_sum[DATA_W-1] != i_a[DATA_W-1]);

  always_comb begin
    w_res = i_sum;
    w_c   = i_carry;
    w_v   = w_v_raw;
    if (i_op == OP_LOAD) begin
      // LOAD bypasses the adder. The data was parked on the B input.
      w_res = i_b;
      w_c   = 1'b0;
      w_v   = 1'b0;
    end
`ifdef ADDSUB_SAT_EN
    else if (((i_op == OP_ADD) || (i_op == OP_SUB)) && w_v_raw) begin
      // An overflow can only push the result away from A's sign, so clamp
      // toward it. V stays set and C keeps the raw carry.
      w_res = i_a[DATA_W-1] ? {1'b1, {(DATA_W-1){1'b0}}}
                            : {1'b0, {(DATA_W-1){1'b1}}};
    end
`endif
  end

  always_comb begin
    o_flags        = 4'b0000;
    o_flags[FLG_C] = w_c;
    o_flags[FLG_V] = w_v;
    o_flags[FLG_N] = w_res[DATA_W-1];
    o_flags[FLG_Z] = (w_res == '0);
  end

  assign o_result = w_res;

endmodule

// File: rtl/addsub_op_sequencer.sv
// addsub_op_sequencer
//   Command-driven 4-bit accumulator stage. It sits in front of an external
//   combinational adder-subtractor. Each accepted command runs
//   IDLE -> EXEC -> RESP. The adder inputs are registered on acceptance, and
//   the adder output is sampled at the end of EXEC. The result is then held
//   in RESP until the consumer takes it.
//
//   Configuration macro: ADDSUB_SAT_EN (saturating ADD/SUB, see addsub_flag_gen).
//
//   Ports:
//     i_clk, i_rst_n                 clock, asynchronous active-low reset
//     i_cmd_valid/o_cmd_ready        command handshake
//     i_cmd_op, i_cmd_data           00 LOAD, 01 ADD, 10 SUB, 11 CMP; operand
//     o_res_valid/i_res_ready        result handshake
//     o_res_data, o_res_flags        result value, {C,V,N,Z}
//     o_acc_out                      current accumulator
//     o_addsub_a/_b/_m               to the adder A, B, M (1 = subtract)
//     i_addsub_sum, i_addsub_carry   from the adder
module addsub_op_sequencer #(
  parameter int         DATA_W  = addsub_op_sequencer_pkg::DATA_W,
  parameter logic [3:0] ACC_RST = 4'h0
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_cmd_valid,
  output logic              o_cmd_ready,
  input  logic [1:0]        i_cmd_op,
  input  logic [DATA_W-1:0] i_cmd_data,
  output logic              o_res_valid,
  input  logic              i_res_ready,
  output logic [DATA_W-1:0] o_res_data,
  output logic [3:0]        o_res_flags,
  output logic [DATA_W-1:0] o_acc_out,
  output logic [DATA_W-1:0] o_addsub_a,
  output logic [DATA_W-1:0] o_addsub_b,
  output logic              o_addsub_m,
  input  logic [DATA_W-1:0] i_addsub_sum,
  input  logic              i_addsub_carry
);

  import addsub_op_sequencer_pkg::*;

  // The external adder is 4 bits wide, so any other width cannot work.
  generate
    if (DATA_W != 4) begin : g_width_check
      $error("addsub_op_sequencer: DATA_W must be 4");
    end
  endgenerate

  logic [1:0]        r_state;
  logic [1:0]        r_op;
  logic [DATA_W-1:0] r_a;
  logic [DATA_W-1:0] r_b;
  logic              r_m;
  logic [DATA_W-1:0] r_acc;
  logic              r_res_valid;
  logic [DATA_W-1:0] r_res_data;
  logic [3:0]        r_res_flags;

  logic [DATA_W-1:0] w_result;
  logic [3:0]        w_flags;

  addsub_flag_gen u_flag_gen (
    .i_a      (r_a),
    .i_b      (r_b),
    .i_m      (r_m),
    .i_sum    (i_addsub_sum),
    .i_carry  (i_addsub_carry),
    .i_op     (r_op),
    .o_result (w_result),
    .o_flags  (w_flags)
  );

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state     <= ST_IDLE;
      r_op        <= OP_LOAD;
      r_a         <= '0;
      r_b         <= '0;
      r_m         <= 1'b0;
      r_acc       <= ACC_RST;
      r_res_valid <= 1'b0;
      r_res_data  <= '0;
      r_res_flags <= 4'b0000;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (i_cmd_valid) begin
            r_op    <= i_cmd_op;
            r_a     <= r_acc;
            r_b     <= i_cmd_data;
            r_m     <= (i_cmd_op == OP_SUB) || (i_cmd_op == OP_CMP);
            r_state <= ST_EXEC;
          end
        end
        ST_EXEC: begin
          r_res_data  <= w_result;
          r_res_flags <= w_flags;
          r_res_valid <= 1'b1;
          if (r_op != OP_CMP) begin
            r_acc <= w_result;
          end
          r_state <= ST_RESP;
        end
        ST_RESP: begin
          if (i_res_ready) begin
            r_res_valid <= 1'b0;
            r_state     <= ST_IDLE;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign o_cmd_ready = (r_state == ST_IDLE);
  assign o_res_valid = r_res_valid;
  assign o_res_data  = r_res_data;
  assign o_res_flags = r_res_flags;
  assign o_acc_out   = r_acc;
  assign o_addsub_a  = r_a;
  assign o_addsub_b  = r_b;
  assign o_addsub_m  = r_m;

endmodule

// File: tb/tb_addsub_op_sequencer.sv
// tb_addsub_op_sequencer
//   Self-checking bench for addsub_op_sequencer. It models the external
//   adder-subtractor and predicts every result with a signed/unsigned
//   arithmetic reference model.
module tb_addsub_op_sequencer;

  logic       clk;
  logic       rst_n;
  logic       cmd_valid;
  logic       cmd_ready;
  logic [1:0] cmd_op;
  logic [3:0] cmd_data;
  logic       res_valid;
  logic       res_ready;
  logic [3:0] res_data;
  logic [3:0] res_flags;
  logic [3:0] acc_out;
  logic [3:0] addsub_a;
  logic [3:0] addsub_b;
  logic       addsub_m;
  logic [3:0] addsub_sum;
  logic       addsub_carry;

  int         n_cmp;
  int         n_err;
  int         n_txn;
  logic [3:0] m_acc;

  addsub_op_sequencer dut (
    .i_clk          (clk),
    .i_rst_n        (rst_n),
    .i_cmd_valid    (cmd_valid),
    .o_cmd_ready    (cmd_ready),
    .i_cmd_op       (cmd_op),
    .i_cmd_data     (cmd_data),
    .o_res_valid    (res_valid),
    .i_res_ready    (res_ready),
    .o_res_data     (res_data),
    .o_res_flags    (res_flags),
    .o_acc_out      (acc_out),
    .o_addsub_a     (addsub_a),
    .o_addsub_b     (addsub_b),
    .o_addsub_m     (addsub_m),
    .i_addsub_sum   (addsub_sum),
    .i_addsub_carry (addsub_carry)
  );

  // External combinational adder-subtractor: A + (B ^ M) + M.
  logic [4:0] adder_out;
  assign adder_out    = {1'b0, addsub_a} + {1'b0, addsub_b ^ {4{addsub_m}}} + {4'b0, addsub_m};
  assign addsub_sum   = adder_out[3:0];
  assign addsub_carry = adder_out[4];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [3:0] obs, input logic [3:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // Reference model based on the arithmetic definition of each operation.
  task automatic ref_model(input logic [1:0] op, input logic [3:0] acc, input logic [3:0] d,
                           output logic [3:0] res, output logic [3:0] flg, output logic [3:0] nacc);
    int sa, sd, sr, u;
    logic c, v;
    sa = acc[3] ? int'(acc) - 16 : int'(acc);
    sd = d[3] ? int'(d) - 16 : int'(d);
    c = 1'b0;
    v = 1'b0;
    res = d;
    sr = 0;
    u = 0;
    if (op == 2'd1) begin
      u = int'(acc) + int'(d);
      sr = sa + sd;
      c = (u > 15);
      v = (sr > 7) || (sr < -8);
      res = 4'(u);
    end else if (op >= 2'd2) begin
      u = int'(acc) + 16 - int'(d);
      sr = sa - sd;
      c = (acc >= d);
      v = (sr > 7) || (sr < -8);
      res = 4'(u);
    end
`ifdef ADDSUB_SAT_EN
    if (((op == 2'd1) || (op == 2'd2)) && v) res = (sa < 0) ? 4'h8 : 4'h7;
`endif
    flg = {c, v, res[3], (res == 4'h0)};
    nacc = (op == 2'd3) ? acc : res;
  endtask

  // One full command: accept, EXEC, RESP (with optional backpressure), handshake.
  task automatic do_cmd(input logic [1:0] op, input logic [3:0] d, input int hold, input bit pulse);
    logic [3:0] e_res, e_flg, e_acc;
    ref_model(op, m_acc, d, e_res, e_flg, e_acc);
    chk("idle_cmd_ready", 4'(cmd_ready), 4'd1);
    cmd_valid = 1'b1;
    cmd_op    = op;
    cmd_data  = d;
    @(posedge clk); #1;
    cmd_valid = 1'b0;
    chk("exec_res_valid", 4'(res_valid), 4'd0);
    chk("exec_cmd_ready", 4'(cmd_ready), 4'd0);
    chk("exec_addsub_m", 4'(addsub_m), 4'((op == 2'd2) || (op == 2'd3)));
    chk("exec_addsub_a", addsub_a, m_acc);
    chk("exec_addsub_b", addsub_b, d);
    @(posedge clk); #1;
    chk("resp_valid", 4'(res_valid), 4'd1);
    chk("resp_data", res_data, e_res);
    chk("resp_flags", res_flags, e_flg);
    for (int i = 0; i < hold; i++) begin
      if (pulse) begin
        cmd_valid = 1'b1;
        cmd_op    = 2'($urandom_range(0, 3));
        cmd_data  = 4'($urandom_range(0, 15));
      end
      @(posedge clk); #1;
      cmd_valid = 1'b0;
      chk("hold_valid", 4'(res_valid), 4'd1);
      chk("hold_data", res_data, e_res);
      chk("hold_flags", res_flags, e_flg);
      chk("hold_cmd_ready", 4'(cmd_ready), 4'd0);
    end
    res_ready = 1'b1;
    @(posedge clk); #1;
    res_ready = 1'b0;
    chk("done_valid", 4'(res_valid), 4'd0);
    chk("done_cmd_ready", 4'(cmd_ready), 4'd1);
    chk("done_acc_out", acc_out, e_acc);
    m_acc = e_acc;
    n_txn++;
    $display("txn %0d op=%0d data=%h hold=%0d res=%h flags=%b acc=%h",
             n_txn, op, d, hold, res_data, res_flags, acc_out);
  endtask

  task automatic chk_reset_outputs(input string pfx);
    chk({pfx, "_cmd_ready"}, 4'(cmd_ready), 4'd1);
    chk({pfx, "_res_valid"}, 4'(res_valid), 4'd0);
    chk({pfx, "_res_data"}, res_data, 4'h0);
    chk({pfx, "_res_flags"}, res_flags, 4'h0);
    chk({pfx, "_acc_out"}, acc_out, 4'h0);
    chk({pfx, "_addsub_a"}, addsub_a, 4'h0);
    chk({pfx, "_addsub_b"}, addsub_b, 4'h0);
    chk({pfx, "_addsub_m"}, 4'(addsub_m), 4'd0);
  endtask

  initial begin
    n_cmp = 0;
    n_err = 0;
    n_txn = 0;
    m_acc = 4'h0;
    rst_n = 1'b0;
    cmd_valid = 1'b0;
    cmd_op = 2'd0;
    cmd_data = 4'h0;
    res_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk_reset_outputs("rst");
    rst_n = 1'b1;
    @(posedge clk); #1;
    chk_reset_outputs("idle");

    // Directed cases.
    do_cmd(2'd0, 4'h5, 0, 1'b0);
    do_cmd(2'd1, 4'h3, 0, 1'b0);
    do_cmd(2'd0, 4'h3, 0, 1'b0);
    do_cmd(2'd2, 4'h3, 0, 1'b0);
    do_cmd(2'd0, 4'h2, 0, 1'b0);
    do_cmd(2'd2, 4'h5, 0, 1'b0);
    do_cmd(2'd0, 4'h4, 0, 1'b0);
    do_cmd(2'd3, 4'h4, 3, 1'b1);
    do_cmd(2'd1, 4'h1, 0, 1'b0);
    do_cmd(2'd0, 4'h1, 0, 1'b0);
    do_cmd(2'd1, 4'hF, 0, 1'b0);

    // Reset asserted in the middle of EXEC.
    do_cmd(2'd0, 4'h9, 0, 1'b0);
    cmd_valid = 1'b1;
    cmd_op    = 2'd2;
    cmd_data  = 4'h3;
    @(posedge clk); #1;
    cmd_valid = 1'b0;
    chk("midexec_m", 4'(addsub_m), 4'd1);
    rst_n = 1'b0;
    #1;
    chk_reset_outputs("async");
    #2;
    rst_n = 1'b1;
    m_acc = 4'h0;
    res_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(posedge clk); #1;
      chk("post_rst_no_result", 4'(res_valid), 4'd0);
    end
    res_ready = 1'b0;

    // Randomized commands with random backpressure and stray command pulses.
    for (int t = 0; t < 60; t++) begin
      do_cmd(2'($urandom_range(0, 3)), 4'($urandom_range(0, 15)),
             int'($urandom_range(0, 3)), 1'($urandom_range(0, 1)));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
